// File: rtl/wb_cmd_master.sv
// Wishbone classic master that drains a request FIFO of WRITE / READ / WAIT_IRQ ops
// and returns read data or status on a response channel with backpressure.
// Optional ack/IRQ timeout: define WB_CMD_MASTER_TIMEOUT_EN (bound = TIMEOUT_CYCLES).
module wb_cmd_master #(
   parameter int ADDR_W         = 2,
   parameter int DATA_W         = 8,
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic [1:0]                 req_op_i,
   input  logic [ADDR_W-1:0]          req_addr_i,
   input  logic [DATA_W-1:0]          req_data_i,
   output logic                       rsp_valid_o,
   input  logic                       rsp_ready_i,
   output logic [DATA_W-1:0]          rsp_data_o,
   output logic                       rsp_err_o,
   output logic                       cyc_o,
   output logic                       stb_o,
   output logic                       we_o,
   output logic [ADDR_W-1:0]          adr_o,
   output logic [DATA_W-1:0]          dat_o,
   input  logic [DATA_W-1:0]          dat_i,
   input  logic                       ack_i,
   input  logic                       irq_i,
   output logic                       busy_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_WIRQ, ST_RSP} state_e;
   typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_WAIT_IRQ, OP_INVALID} op_e;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("wb_cmd_master: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
   end

   op_e               op_mem   [DEPTH];
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   state_e            state;
   logic              push;
   logic              pop;
   op_e               head_op;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0] tmo_cnt;
`endif

   // A full FIFO refuses the push even when the FSM pops on the same edge.
   assign req_ready_o = (count_o != CNT_W'(DEPTH));
   assign push        = req_valid_i && req_ready_o;
   assign pop         = (state == ST_IDLE) && (count_o != '0);
   assign head_op     = op_mem[rd_ptr];
   assign busy_o      = (count_o != '0) || (state != ST_IDLE);

   // NOTE: the entry storage has no reset; the pointers and count alone define
   // which entries are valid, so clearing the array would only cost reset routing.
   always_ff @(posedge clk_i) begin
      if (push) begin
         op_mem[wr_ptr]   <= op_e'(req_op_i);
         addr_mem[wr_ptr] <= req_addr_i;
         data_mem[wr_ptr] <= req_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_o <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_o <= count_o + CNT_W'(1);
            2'b01:   count_o <= count_o - CNT_W'(1);
            default: count_o <= count_o;
         endcase
      end
   end

   // NOTE: every register here is assigned with <= so all branches read the
   // pre-edge values (we_o below still identifies the op on the ack edge).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= ST_IDLE;
         cyc_o       <= 1'b0;
         stb_o       <= 1'b0;
         we_o        <= 1'b0;
         adr_o       <= '0;
         dat_o       <= '0;
         rsp_valid_o <= 1'b0;
         rsp_data_o  <= '0;
         rsp_err_o   <= 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
         tmo_cnt     <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                  tmo_cnt <= '0;
`endif
                  case (head_op)
                     OP_WRITE, OP_READ: begin
                        state <= ST_BUS;
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        we_o  <= (head_op == OP_WRITE);
                        adr_o <= addr_mem[rd_ptr];
                        dat_o <= data_mem[rd_ptr];
                     end
                     OP_WAIT_IRQ: state <= ST_WIRQ;
                     default: begin
                        state       <= ST_RSP;
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= '0;
                        rsp_err_o   <= 1'b1;
                     end
                  endcase
               end
            end
            ST_BUS: begin
               if (ack_i) begin
                  cyc_o <= 1'b0;
                  stb_o <= 1'b0;
                  we_o  <= 1'b0;
                  if (we_o) begin
                     state <= ST_IDLE;
                  end else begin
                     state       <= ST_RSP;
                     rsp_valid_o <= 1'b1;
                     rsp_data_o  <= dat_i;
                     rsp_err_o   <= 1'b0;
                  end
               end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  cyc_o       <= 1'b0;
                  stb_o       <= 1'b0;
                  we_o        <= 1'b0;
                  state       <= ST_RSP;
                  rsp_valid_o <= 1'b1;
                  rsp_data_o  <= '0;
                  rsp_err_o   <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
`endif
            end
            ST_WIRQ: begin
               if (irq_i) begin
                  state       <= ST_RSP;
                  rsp_valid_o <= 1'b1;
                  rsp_data_o  <= '0;
                  rsp_err_o   <= 1'b0;
               end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  state       <= ST_RSP;
                  rsp_valid_o <= 1'b1;
                  rsp_data_o  <= '0;
                  rsp_err_o   <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
`endif
            end
            ST_RSP: begin
               if (rsp_ready_i) begin
                  state       <= ST_IDLE;
                  rsp_valid_o <= 1'b0;
                  rsp_data_o  <= '0;
                  rsp_err_o   <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed timing scenarios plus a randomized
// run scored against an in-order queue model with a memory-backed Wishbone slave.
module tb_wb_cmd_master;

   localparam logic [1:0] OP_WR = 2'd0, OP_RD = 2'd1, OP_WI = 2'd2, OP_INV = 2'd3;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
   localparam int IRQ_DELAY = 5;
`else
   localparam int IRQ_DELAY = 10;
`endif

   typedef struct packed { logic we; logic [1:0] adr; logic [7:0] dat; } bus_t;
   typedef struct packed { logic [7:0] data; logic err; } rsp_t;

   logic       clk_i = 1'b0, rst_i = 1'b1;
   logic       req_valid_i = 1'b0, req_ready_o;
   logic [1:0] req_op_i = '0, req_addr_i = '0;
   logic [7:0] req_data_i = '0;
   logic       rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o;
   logic [7:0] rsp_data_o;
   logic       cyc_o, stb_o, we_o;
   logic [1:0] adr_o;
   logic [7:0] dat_o, dat_i = '0;
   logic       ack_i = 1'b0, irq_i = 1'b0, busy_o;
   logic [2:0] count_o;

   int n_cmp = 0;
   int n_err = 0;
   bus_t exp_bus[$];
   rsp_t exp_rsp[$];

   wb_cmd_master #(.ADDR_W(2), .DATA_W(8), .DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
      .req_addr_i(req_addr_i), .req_data_i(req_data_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
      .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i),
      .busy_o(busy_o), .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Present one request and wait (bounded) for the edge that accepts it.
   task automatic push_op(input logic [1:0] op, input logic [1:0] a, input logic [7:0] d);
      bit done = 1'b0;
      req_op_i = op; req_addr_i = a; req_data_i = d; req_valid_i = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         done = req_ready_o;
         tick();
      end
      req_valid_i = 1'b0;
      n_cmp++; if (!done) begin n_err++; $display("FAIL push_accept: got ready=0 for 50 cycles want accepted"); end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick(); tick();
      n_cmp++; if ({cyc_o, stb_o, we_o} !== 3'b000) begin n_err++; $display("FAIL rst_bus_ctl: got %b want 000", {cyc_o, stb_o, we_o}); end
      n_cmp++; if ({adr_o, dat_o} !== 10'h0) begin n_err++; $display("FAIL rst_adr_dat: got %h want 000", {adr_o, dat_o}); end
      n_cmp++; if ({rsp_valid_o, rsp_err_o, rsp_data_o} !== 10'h0) begin n_err++; $display("FAIL rst_rsp: got %h want 000", {rsp_valid_o, rsp_err_o, rsp_data_o}); end
      n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", req_ready_o); end
      n_cmp++; if ({busy_o, count_o} !== 4'h0) begin n_err++; $display("FAIL rst_busy_count: got %h want 0", {busy_o, count_o}); end
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_write();
      int hi = 0;
      push_op(OP_WR, 2'd2, 8'h06);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (cyc_o && stb_o && we_o && adr_o == 2'd2 && dat_o == 8'h06) hi++;
      end
      ack_i = 1'b1;
      tick();
      ack_i = 1'b0;
      n_cmp++; if (hi !== 3) begin n_err++; $display("FAIL wr_cycle_len: got %0d want 3", hi); end
      n_cmp++; if ({cyc_o, stb_o, we_o} !== 3'b000) begin n_err++; $display("FAIL wr_drop: got %b want 000", {cyc_o, stb_o, we_o}); end
      n_cmp++; if ({adr_o, dat_o} !== {2'd2, 8'h06}) begin n_err++; $display("FAIL wr_hold: got %h want %h", {adr_o, dat_o}, {2'd2, 8'h06}); end
      tick(); tick();
      n_cmp++; if ({rsp_valid_o, busy_o} !== 2'b00) begin n_err++; $display("FAIL wr_no_rsp: got %b want 00", {rsp_valid_o, busy_o}); end
   endtask

   task automatic test_read_backpressure();
      rsp_ready_i = 1'b0;
      push_op(OP_RD, 2'd1, 8'h00);
      push_op(OP_WR, 2'd3, 8'h77);
      n_cmp++; if ({cyc_o, we_o, adr_o, count_o} !== {1'b1, 1'b0, 2'd1, 3'd1}) begin n_err++; $display("FAIL rd_start: got %h want %h", {cyc_o, we_o, adr_o, count_o}, {1'b1, 1'b0, 2'd1, 3'd1}); end
      ack_i = 1'b1; dat_i = 8'hA5;
      tick();
      ack_i = 1'b0; dat_i = 8'h00;
      n_cmp++; if ({cyc_o, rsp_valid_o, rsp_err_o, rsp_data_o} !== {3'b010, 8'hA5}) begin n_err++; $display("FAIL rd_rsp: got %h want %h", {cyc_o, rsp_valid_o, rsp_err_o, rsp_data_o}, {3'b010, 8'hA5}); end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if ({cyc_o, rsp_valid_o, rsp_data_o} !== {2'b01, 8'hA5}) begin n_err++; $display("FAIL rd_hold%0d: got %h want %h", i, {cyc_o, rsp_valid_o, rsp_data_o}, {2'b01, 8'hA5}); end
      end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      n_cmp++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL rd_accept: got %b want 0", rsp_valid_o); end
      tick();
      n_cmp++; if ({cyc_o, we_o, adr_o, dat_o} !== {2'b11, 2'd3, 8'h77}) begin n_err++; $display("FAIL rd_next_wr: got %h want %h", {cyc_o, we_o, adr_o, dat_o}, {2'b11, 2'd3, 8'h77}); end
      ack_i = 1'b1;
      tick();
      ack_i = 1'b0;
      tick();
      n_cmp++; if ({cyc_o, rsp_valid_o, busy_o} !== 3'b000) begin n_err++; $display("FAIL rd_done: got %b want 000", {cyc_o, rsp_valid_o, busy_o}); end
   endtask

   task automatic test_full();
      int idx = 0;
      push_op(OP_WR, 2'd3, 8'h10);
      tick();
      n_cmp++; if ({cyc_o, count_o} !== 4'b1000) begin n_err++; $display("FAIL full_blocker: got %b want 1000", {cyc_o, count_o}); end
      for (int i = 0; i < 5; i++) begin
         req_valid_i = 1'b1; req_op_i = OP_WR; req_addr_i = 2'(i); req_data_i = 8'h20 + 8'(i);
         if (i < 4) begin
            n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL full_ready%0d: got %b want 1", i, req_ready_o); end
            tick();
         end
      end
      tick(); tick();
      n_cmp++; if ({req_ready_o, count_o} !== 4'b0100) begin n_err++; $display("FAIL full_block: got %b want 0100", {req_ready_o, count_o}); end
      ack_i = 1'b1;
      tick();
      ack_i = 1'b0;
      n_cmp++; if ({cyc_o, req_ready_o, count_o} !== 5'b00100) begin n_err++; $display("FAIL full_ack: got %b want 00100", {cyc_o, req_ready_o, count_o}); end
      tick();
      n_cmp++; if ({cyc_o, req_ready_o, count_o} !== 5'b11011) begin n_err++; $display("FAIL full_pop: got %b want 11011", {cyc_o, req_ready_o, count_o}); end
      tick();
      req_valid_i = 1'b0;
      n_cmp++; if (count_o !== 3'd4) begin n_err++; $display("FAIL full_fifth: got %0d want 4", count_o); end
      for (int c = 0; c < 100 && !(idx == 5 && !busy_o); c++) begin
         if (ack_i) ack_i = 1'b0;
         else if (cyc_o) begin
            n_cmp++;
            if (idx >= 5) begin n_err++; $display("FAIL full_extra: got bus cycle adr=%h want none", adr_o); end
            else if ({adr_o, dat_o} !== {2'(idx), 8'h20 + 8'(idx)}) begin n_err++; $display("FAIL full_order%0d: got %h want %h", idx, {adr_o, dat_o}, {2'(idx), 8'h20 + 8'(idx)}); end
            idx++;
            ack_i = 1'b1;
         end
         tick();
      end
      ack_i = 1'b0;
      n_cmp++; if (idx !== 5) begin n_err++; $display("FAIL full_drain: got %0d cycles want 5", idx); end
   endtask

   task automatic test_wait_irq();
      int early = 0;
      irq_i = 1'b0;
      push_op(OP_WI, 2'd0, 8'h00);
      push_op(OP_RD, 2'd0, 8'h00);
      for (int i = 0; i < IRQ_DELAY; i++) begin
         if (rsp_valid_o || cyc_o) early++;
         tick();
      end
      n_cmp++; if (early !== 0) begin n_err++; $display("FAIL irq_early: got %0d active cycles want 0", early); end
      irq_i = 1'b1;
      tick();
      irq_i = 1'b0;
      n_cmp++; if ({cyc_o, rsp_valid_o, rsp_err_o, rsp_data_o} !== {3'b010, 8'h00}) begin n_err++; $display("FAIL irq_rsp: got %h want %h", {cyc_o, rsp_valid_o, rsp_err_o, rsp_data_o}, {3'b010, 8'h00}); end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      tick();
      n_cmp++; if ({cyc_o, we_o, adr_o} !== 4'b1000) begin n_err++; $display("FAIL irq_then_rd: got %b want 1000", {cyc_o, we_o, adr_o}); end
      ack_i = 1'b1; dat_i = 8'h3C;
      tick();
      ack_i = 1'b0; dat_i = 8'h00;
      n_cmp++; if ({rsp_valid_o, rsp_data_o} !== {1'b1, 8'h3C}) begin n_err++; $display("FAIL irq_rd_data: got %h want %h", {rsp_valid_o, rsp_data_o}, {1'b1, 8'h3C}); end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      // IRQ already high when the op is popped completes on the first WIRQ cycle.
      irq_i = 1'b1;
      push_op(OP_WI, 2'd0, 8'h00);
      tick();
      n_cmp++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL irq_lvl_entry: got %b want 0", rsp_valid_o); end
      tick();
      irq_i = 1'b0;
      n_cmp++; if ({rsp_valid_o, rsp_err_o} !== 2'b10) begin n_err++; $display("FAIL irq_lvl_rsp: got %b want 10", {rsp_valid_o, rsp_err_o}); end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
   endtask

   task automatic test_invalid();
      int bus_seen = 0;
      push_op(OP_INV, 2'd1, 8'hFF);
      if (cyc_o) bus_seen++;
      tick();
      if (cyc_o) bus_seen++;
      n_cmp++; if ({rsp_valid_o, rsp_err_o, rsp_data_o} !== {2'b11, 8'h00}) begin n_err++; $display("FAIL inv_rsp: got %h want %h", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b11, 8'h00}); end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      if (cyc_o) bus_seen++;
      n_cmp++; if (bus_seen !== 0) begin n_err++; $display("FAIL inv_no_bus: got %0d bus cycles want 0", bus_seen); end
   endtask

   task automatic test_back_to_back();
      rsp_ready_i = 1'b1;
      push_op(OP_RD, 2'd2, 8'h00);
      push_op(OP_RD, 2'd3, 8'h00);
      n_cmp++; if ({cyc_o, adr_o} !== 3'b110) begin n_err++; $display("FAIL b2b_first: got %b want 110", {cyc_o, adr_o}); end
      ack_i = 1'b1; dat_i = 8'h5A;
      tick();
      ack_i = 1'b0; dat_i = 8'h00;
      n_cmp++; if ({cyc_o, rsp_valid_o, rsp_data_o} !== {2'b01, 8'h5A}) begin n_err++; $display("FAIL b2b_rsp1: got %h want %h", {cyc_o, rsp_valid_o, rsp_data_o}, {2'b01, 8'h5A}); end
      tick();
      n_cmp++; if ({cyc_o, rsp_valid_o} !== 2'b00) begin n_err++; $display("FAIL b2b_gap: got %b want 00", {cyc_o, rsp_valid_o}); end
      tick();
      n_cmp++; if ({cyc_o, adr_o} !== 3'b111) begin n_err++; $display("FAIL b2b_second: got %b want 111", {cyc_o, adr_o}); end
      ack_i = 1'b1; dat_i = 8'hC3;
      tick();
      ack_i = 1'b0; dat_i = 8'h00;
      n_cmp++; if ({rsp_valid_o, rsp_data_o} !== {1'b1, 8'hC3}) begin n_err++; $display("FAIL b2b_rsp2: got %h want %h", {rsp_valid_o, rsp_data_o}, {1'b1, 8'hC3}); end
      tick();
      rsp_ready_i = 1'b0;
   endtask

`ifdef WB_CMD_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      int hi = 0;
      push_op(OP_WR, 2'd1, 8'h42);
      for (int i = 0; i < 30; i++) begin
         tick();
         if (cyc_o) hi++;
         else break;
      end
      n_cmp++; if (hi !== 8) begin n_err++; $display("FAIL tmo_len: got %0d cycles want 8", hi); end
      n_cmp++; if ({rsp_valid_o, rsp_err_o, rsp_data_o} !== {2'b11, 8'h00}) begin n_err++; $display("FAIL tmo_rsp: got %h want %h", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b11, 8'h00}); end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
   endtask
`endif

   task automatic test_reset_mid_bus();
      int bus_after = 0;
      push_op(OP_RD, 2'd1, 8'h00);
      push_op(OP_WR, 2'd2, 8'h11);
      push_op(OP_WR, 2'd3, 8'h22);
      n_cmp++; if ({cyc_o, count_o} !== 4'b1010) begin n_err++; $display("FAIL mid_pre: got %b want 1010", {cyc_o, count_o}); end
      #2 rst_i = 1'b1;
      #1;
      n_cmp++; if ({cyc_o, stb_o, we_o, rsp_valid_o, busy_o} !== 5'b0) begin n_err++; $display("FAIL mid_async: got %b want 00000", {cyc_o, stb_o, we_o, rsp_valid_o, busy_o}); end
      n_cmp++; if ({req_ready_o, count_o, adr_o, dat_o} !== {1'b1, 3'd0, 10'h0}) begin n_err++; $display("FAIL mid_state: got %h want %h", {req_ready_o, count_o, adr_o, dat_o}, {1'b1, 3'd0, 10'h0}); end
      tick();
      rst_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (cyc_o || rsp_valid_o) bus_after++;
      end
      n_cmp++; if (bus_after !== 0) begin n_err++; $display("FAIL mid_flush: got %0d active cycles want 0", bus_after); end
   endtask

   task automatic test_random();
      logic [7:0] slave_mem [4];
      logic [7:0] model_mem [4];
      int   pushed = 0, wait_cnt = 0, irq_gap = 0, budget = 0;
      bit   in_txn = 1'b0, held = 1'b0, accept = 1'b0;
      rsp_t held_rsp, r;
      bus_t b;
      for (int i = 0; i < 4; i++) begin
         slave_mem[i] = 8'($urandom);
         model_mem[i] = slave_mem[i];
      end
      while ((pushed < 60 || exp_bus.size() != 0 || exp_rsp.size() != 0 || busy_o) && budget < 5000) begin
         budget++;
         // Wishbone slave: random wait states, memory behind it.
         if (ack_i) begin
            ack_i = 1'b0; in_txn = 1'b0; dat_i = 8'($urandom);
            n_cmp++; if (cyc_o !== 1'b0) begin n_err++; $display("FAIL rnd_ack_drop: got cyc=%b want 0", cyc_o); end
         end else if (cyc_o && stb_o) begin
            if (!in_txn) begin
               in_txn = 1'b1;
               wait_cnt = $urandom_range(0, 3);
               n_cmp++;
               if (exp_bus.size() == 0) begin n_err++; $display("FAIL rnd_bus_extra: got %h want none", {we_o, adr_o, dat_o}); end
               else begin
                  b = exp_bus.pop_front();
                  if ({we_o, adr_o, dat_o} !== b) begin n_err++; $display("FAIL rnd_bus: got %h want %h", {we_o, adr_o, dat_o}, b); end
               end
            end
            if (wait_cnt == 0) begin
               ack_i = 1'b1;
               if (we_o) slave_mem[adr_o] = dat_o;
               else dat_i = slave_mem[adr_o];
            end else begin
               wait_cnt--;
               dat_i = 8'($urandom);
            end
         end
         // Response consumer with random backpressure; held responses must stay stable.
         if (rsp_valid_o) begin
            if (held) begin
               n_cmp++; if ({rsp_data_o, rsp_err_o} !== held_rsp) begin n_err++; $display("FAIL rnd_rsp_stable: got %h want %h", {rsp_data_o, rsp_err_o}, held_rsp); end
            end
            rsp_ready_i = ($urandom_range(0, 2) != 0);
            if (rsp_ready_i) begin
               held = 1'b0;
               n_cmp++;
               if (exp_rsp.size() == 0) begin n_err++; $display("FAIL rnd_rsp_extra: got %h want none", {rsp_data_o, rsp_err_o}); end
               else begin
                  r = exp_rsp.pop_front();
                  if ({rsp_data_o, rsp_err_o} !== r) begin n_err++; $display("FAIL rnd_rsp: got %h want %h", {rsp_data_o, rsp_err_o}, r); end
               end
            end else begin
               held = 1'b1;
               held_rsp = {rsp_data_o, rsp_err_o};
            end
         end else begin
            held = 1'b0;
            rsp_ready_i = 1'($urandom_range(0, 1));
         end
         // Interrupt source with a bounded gap between pulses.
         irq_i = (irq_gap >= 4) || ($urandom_range(0, 3) == 0);
         irq_gap = irq_i ? 0 : irq_gap + 1;
         // Request producer; the reference model records each op on its accepting edge.
         if (accept) req_valid_i = 1'b0;
         if (pushed < 60 && !req_valid_i && $urandom_range(0, 1) == 1) begin
            req_valid_i = 1'b1;
            req_op_i    = 2'($urandom_range(0, 3));
            req_addr_i  = 2'($urandom_range(0, 3));
            req_data_i  = 8'($urandom);
         end
         accept = req_valid_i && req_ready_o;
         if (accept) begin
            pushed++;
            case (req_op_i)
               OP_WR: begin
                  exp_bus.push_back({1'b1, req_addr_i, req_data_i});
                  model_mem[req_addr_i] = req_data_i;
               end
               OP_RD: begin
                  exp_bus.push_back({1'b0, req_addr_i, req_data_i});
                  exp_rsp.push_back({model_mem[req_addr_i], 1'b0});
               end
               OP_WI:   exp_rsp.push_back({8'h00, 1'b0});
               default: exp_rsp.push_back({8'h00, 1'b1});
            endcase
         end
         tick();
      end
      req_valid_i = 1'b0; rsp_ready_i = 1'b0; ack_i = 1'b0; irq_i = 1'b0;
      n_cmp++;
      if (pushed != 60 || exp_bus.size() != 0 || exp_rsp.size() != 0 || busy_o) begin
         n_err++;
         $display("FAIL rnd_drain: got pushed=%0d bus_left=%0d rsp_left=%0d busy=%b want 60/0/0/0", pushed, exp_bus.size(), exp_rsp.size(), busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_backpressure();
      test_full();
      test_wait_irq();
      test_invalid();
      test_back_to_back();
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      test_reset_mid_bus();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
